branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- Two-wide in-order queue holding every fetch-time branch prediction until the branch retires.
- At retire, compares each retiring branch's resolved outcome against its queued prediction.
- Emits registered BTB/PHT/BHT update strobes, a squash pulse and a redirect PC on mispredict.
- Sits between the IF-stage predictor outputs and the ROB retire ports; it is the checking/training end of the branch_predictor interface.

Parameters:
- BRQ_DEPTH, 16, number of entries; power of two, at least 4.
- BRQ_IDX_W, $clog2(BRQ_DEPTH), pointer width.
- `XLEN (global), 32, PC/target width.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- push_valid  in  2  per-slot prediction push from IF; slot 1 only valid with slot 0.
- push_pc  in  2x`XLEN  PC of pushed branch.
- push_pred_taken  in  2  predicted direction.
- push_pred_target  in  2x`XLEN  predicted target (NPC when predicted not-taken).
- push_ready  out  1  high when at least 2 entries are free.
- rt_valid  in  2  retiring branch per slot; slot 1 only valid with slot 0.
- rt_pc  in  2x`XLEN  PC of the retiring branch.
- rt_taken  in  2  resolved direction.
- rt_target  in  2x`XLEN  resolved taken target.
- upd_en  out  2  registered predictor-training strobe per slot.
- upd_pc  out  2x`XLEN  registered PC for training.
- upd_taken  out  2  registered resolved direction.
- upd_target  out  2x`XLEN  registered resolved target.
- squash  out  1  one-cycle pulse on mispredict.
- redirect_pc  out  `XLEN  correct fetch PC, valid while squash = 1.
- order_err  out  1  sticky; set when retire PC does not match the head entry, or on retire while empty.
- count  out  BRQ_IDX_W+1  current occupancy.

Behaviour:
- Reset (reset = 0, async): head = tail = count = 0; all outputs 0, including order_err. Entry contents are don't-care.
- push_ready = (BRQ_DEPTH - count) >= 2. This is combinational from registered count only.
- Pushes are accepted at the clock edge only when push_ready = 1 and no mispredict is being flushed.
- Pushes are written in slot order to tail and tail+1; tail advances by the number pushed, modulo BRQ_DEPTH (wrap-around).
- Retire, per slot i in order:
  - compare against entry head+i;
  - mispredict_i = (pred_taken != rt_taken) | (rt_taken & pred_target != rt_target).
- If slot 0 mispredicts, slot 1 is discarded: not popped, no upd_en[1].
- Pop count = number of valid, non-discarded slots; head advances modulo BRQ_DEPTH.
- Update latency is 1 cycle. upd_* registers capture the retiring slot data at the edge; upd_en is 1 for each consumed slot, otherwise 0.
- On any mispredict in cycle N:
  - squash = 1 in cycle N+1;
  - redirect_pc = rt_taken ? rt_target : rt_pc + 4 of the mispredicting slot;
  - at the end of cycle N the queue is cleared (head = tail, count = 0);
  - pushes in cycle N are dropped; pushes in cycle N+1 are also dropped (wrong-path fetch).
- squash is a pulse. Back-to-back mispredicts in N and N+1 cannot occur because the queue is empty in N+1; retire on empty sets order_err.
- Simultaneous push and retire in the same cycle: count_next = count + pushed - popped. The full push_ready gate guarantees no overflow.
- order_err is set when rt_pc[i] != entry PC or when rt_valid[i] exceeds count. That slot is still treated as consumed. order_err clears only on reset.
- Reset asserted mid-operation clears all state immediately, including a pending squash.

Optional Feature:
- Macro: BRQ_STATS_EN.
- Defined:
  - adds 32-bit saturating outputs stat_branches (total retired branch slots) and stat_mispredicts;
  - both are reset to 0 and updated at the same edge as upd_en.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then push 2 (PC 0x100 predicted taken to 0x200; PC 0x104 not-taken to 0x108), then retire both matching -> next cycle upd_en = 2'b11, upd_pc = {0x104, 0x100}, squash = 0, count = 0.
- Push PC 0x40 predicted not-taken; retire with rt_taken = 1, rt_target = 0x80 -> squash = 1 one cycle later, redirect_pc = 0x80, count = 0; a push in the same cycle is dropped.
- Slot 0 mispredicts (predicted taken, actual not-taken, PC 0x10) while slot 1 is also valid -> redirect_pc = 0x14, upd_en = 2'b01, slot 1 is not popped but the queue is cleared.
- Fill to BRQ_DEPTH - 1 -> push_ready = 0 and pushes are ignored. Retire 1 -> push_ready returns to 1.
- Cycle 3 x BRQ_DEPTH pushes and retires concurrently -> pointers wrap and all upd_pc values match push order, with no order_err.
- Retire with PC 0x999 against head PC 0x100 -> order_err = 1, and it stays 1 until reset = 0.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: two-wide in-order queue of fetch-time branch
// predictions, checked against resolved outcomes at retire. Produces
// registered predictor-training strobes, a squash pulse and a redirect PC.
// Optional feature macro: BRQ_STATS_EN adds saturating retire/mispredict
// counters (stat_branches, stat_mispredicts).

`ifndef XLEN
`define XLEN 32
`endif

module branch_resolve_queue #(
    parameter int BRQ_DEPTH = 16,
    parameter int BRQ_IDX_W = $clog2(BRQ_DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             push_valid,
    input  logic [2*`XLEN-1:0]     push_pc,
    input  logic [1:0]             push_pred_taken,
    input  logic [2*`XLEN-1:0]     push_pred_target,
    output logic                   push_ready,
    input  logic [1:0]             rt_valid,
    input  logic [2*`XLEN-1:0]     rt_pc,
    input  logic [1:0]             rt_taken,
    input  logic [2*`XLEN-1:0]     rt_target,
    output logic [1:0]             upd_en,
    output logic [2*`XLEN-1:0]     upd_pc,
    output logic [1:0]             upd_taken,
    output logic [2*`XLEN-1:0]     upd_target,
    output logic                   squash,
    output logic [`XLEN-1:0]       redirect_pc,
    output logic                   order_err,
`ifdef BRQ_STATS_EN
    output logic [31:0]            stat_branches,
    output logic [31:0]            stat_mispredicts,
`endif
    output logic [BRQ_IDX_W:0]     count
);

    localparam int XW    = `XLEN;
    localparam int CNT_W = BRQ_IDX_W + 1;

    // Prediction storage
    logic [XW-1:0] ent_pc     [BRQ_DEPTH];
    logic          ent_taken  [BRQ_DEPTH];
    logic [XW-1:0] ent_target [BRQ_DEPTH];

    logic [BRQ_IDX_W-1:0] head;
    logic [BRQ_IDX_W-1:0] tail;

    // Per-slot retire evaluation
    logic [BRQ_IDX_W-1:0] rd_idx   [2];
    logic [XW-1:0]        slot_pc  [2];
    logic [XW-1:0]        slot_tgt [2];
    logic [1:0]           in_range;
    logic [1:0]           mismatch;
    logic [1:0]           consume;
    logic [1:0]           mp;
    logic [1:0]           bad_order;
    logic                 mispredict;
    logic [XW-1:0]        fix_pc;
    logic [CNT_W-1:0]     pop_cnt;

    // Push acceptance
    logic                 push_ok;
    logic [1:0]           push_en;
    logic [CNT_W-1:0]     push_cnt;

    assign push_ready = (count <= CNT_W'(BRQ_DEPTH - 2));

    // Retire checking: compare each retiring slot with head+i and decide what is consumed
    always_comb begin
        rd_idx[0]   = head;
        rd_idx[1]   = head + BRQ_IDX_W'(1);
        in_range[0] = (count != '0);
        in_range[1] = (count >= CNT_W'(2));
        for (int i = 0; i < 2; i++) begin
            slot_pc[i]  = rt_pc[i*XW +: XW];
            slot_tgt[i] = rt_target[i*XW +: XW];
            mismatch[i] = (ent_taken[rd_idx[i]] != rt_taken[i]) |
                          (rt_taken[i] & (ent_target[rd_idx[i]] != slot_tgt[i]));
        end

        // A slot without a backing entry has nothing to compare against, so it
        // can only raise order_err, never a mispredict.
        consume[0] = rt_valid[0];
        mp[0]      = consume[0] & in_range[0] & mismatch[0];
        consume[1] = rt_valid[1] & rt_valid[0] & ~mp[0];
        mp[1]      = consume[1] & in_range[1] & mismatch[1];

        for (int i = 0; i < 2; i++) begin
            bad_order[i] = consume[i] &
                           (~in_range[i] | (slot_pc[i] != ent_pc[rd_idx[i]]));
        end

        mispredict = |mp;
        if (mp[0]) begin
            fix_pc = rt_taken[0] ? slot_tgt[0] : slot_pc[0] + XW'(4);
        end else begin
            fix_pc = rt_taken[1] ? slot_tgt[1] : slot_pc[1] + XW'(4);
        end

        // Only slots that actually hold an entry move head/count; this keeps a
        // retire-on-empty from underflowing the occupancy.
        pop_cnt = CNT_W'(consume[0] & in_range[0]) + CNT_W'(consume[1] & in_range[1]);

        // Wrong-path fetch: drop pushes in the mispredict cycle and the squash cycle.
        push_ok    = push_ready & ~mispredict & ~squash;
        push_en[0] = push_ok & push_valid[0];
        push_en[1] = push_ok & push_valid[0] & push_valid[1];
        push_cnt   = CNT_W'(push_en[0]) + CNT_W'(push_en[1]);
    end

    // Entry writes at tail and tail+1
    // NOTE: storage has no reset; occupancy is tracked by head/tail/count, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (push_en[0]) begin
            ent_pc[tail]     <= push_pc[0 +: XW];
            ent_taken[tail]  <= push_pred_taken[0];
            ent_target[tail] <= push_pred_target[0 +: XW];
        end
        if (push_en[1]) begin
            ent_pc[tail + BRQ_IDX_W'(1)]     <= push_pc[XW +: XW];
            ent_taken[tail + BRQ_IDX_W'(1)]  <= push_pred_taken[1];
            ent_target[tail + BRQ_IDX_W'(1)] <= push_pred_target[XW +: XW];
        end
    end

    // Pointers, occupancy, training strobes, squash/redirect and sticky order error
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            upd_en      <= '0;
            upd_pc      <= '0;
            upd_taken   <= '0;
            upd_target  <= '0;
            squash      <= 1'b0;
            redirect_pc <= '0;
            order_err   <= 1'b0;
        end else begin
            if (mispredict) begin
                // Pushes are dropped this cycle, so tail is stable; flush by
                // pulling head up to it.
                head  <= tail;
                count <= '0;
            end else begin
                head  <= head + pop_cnt[BRQ_IDX_W-1:0];
                tail  <= tail + push_cnt[BRQ_IDX_W-1:0];
                count <= count + push_cnt - pop_cnt;
            end

            upd_en <= consume;
            for (int i = 0; i < 2; i++) begin
                if (consume[i]) begin
                    upd_pc[i*XW +: XW]     <= slot_pc[i];
                    upd_taken[i]           <= rt_taken[i];
                    upd_target[i*XW +: XW] <= slot_tgt[i];
                end
            end

            squash <= mispredict;
            if (mispredict) begin
                redirect_pc <= fix_pc;
            end

            if (|bad_order) begin
                order_err <= 1'b1;
            end
        end
    end

`ifdef BRQ_STATS_EN
    logic [32:0] br_sum;
    logic [32:0] mp_sum;

    // Saturating sums of retired slots and mispredicts
    always_comb begin
        br_sum = {1'b0, stat_branches} + 33'(consume[0]) + 33'(consume[1]);
        mp_sum = {1'b0, stat_mispredicts} + 33'(mispredict);
    end

    // Statistics counters, updated on the same edge as upd_en
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_branches    <= br_sum[32] ? 32'hFFFF_FFFF : br_sum[31:0];
            stat_mispredicts <= mp_sum[32] ? 32'hFFFF_FFFF : mp_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: a table of directed
// single-cycle vectors followed by hand-written multi-cycle sequences
// (fill/backpressure, wrap-around streaming, mid-operation reset,
// order error stickiness).

module tb_branch_resolve_queue;

    localparam int DEPTH = 16;
    localparam int IW    = $clog2(DEPTH);

    logic        clock;
    logic        reset;
    logic [1:0]  push_valid;
    logic [63:0] push_pc;
    logic [1:0]  push_pred_taken;
    logic [63:0] push_pred_target;
    logic        push_ready;
    logic [1:0]  rt_valid;
    logic [63:0] rt_pc;
    logic [1:0]  rt_taken;
    logic [63:0] rt_target;
    logic [1:0]  upd_en;
    logic [63:0] upd_pc;
    logic [1:0]  upd_taken;
    logic [63:0] upd_target;
    logic        squash;
    logic [31:0] redirect_pc;
    logic        order_err;
    logic [IW:0] count;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_resolve_queue #(.BRQ_DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .push_valid       (push_valid),
        .push_pc          (push_pc),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .push_ready       (push_ready),
        .rt_valid         (rt_valid),
        .rt_pc            (rt_pc),
        .rt_taken         (rt_taken),
        .rt_target        (rt_target),
        .upd_en           (upd_en),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .squash           (squash),
        .redirect_pc      (redirect_pc),
        .order_err        (order_err),
`ifdef BRQ_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .count            (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  pv;
        logic [31:0] ppc0, ppc1;
        logic [1:0]  ptk;
        logic [31:0] ptg0, ptg1;
        logic [1:0]  rv;
        logic [31:0] rpc0, rpc1;
        logic [1:0]  rtk;
        logic [31:0] rtg0, rtg1;
        logic [1:0]  e_en;
        logic [31:0] e_pc0, e_pc1;
        logic [1:0]  e_tk;
        logic [31:0] e_tg0;
        logic        e_squash;
        logic [31:0] e_redir;
        logic [4:0]  e_count;
        logic        e_ready;
        logic        e_oerr;
    } vec_t;

    function automatic vec_t mk(
        input logic [1:0] pv, input logic [31:0] ppc0, input logic [31:0] ppc1,
        input logic [1:0] ptk, input logic [31:0] ptg0, input logic [31:0] ptg1,
        input logic [1:0] rv, input logic [31:0] rpc0, input logic [31:0] rpc1,
        input logic [1:0] rtk, input logic [31:0] rtg0, input logic [31:0] rtg1,
        input logic [1:0] e_en, input logic [31:0] e_pc0, input logic [31:0] e_pc1,
        input logic [1:0] e_tk, input logic [31:0] e_tg0, input logic e_squash,
        input logic [31:0] e_redir, input logic [4:0] e_count, input logic e_ready,
        input logic e_oerr);
        vec_t v;
        v.pv = pv; v.ppc0 = ppc0; v.ppc1 = ppc1; v.ptk = ptk; v.ptg0 = ptg0; v.ptg1 = ptg1;
        v.rv = rv; v.rpc0 = rpc0; v.rpc1 = rpc1; v.rtk = rtk; v.rtg0 = rtg0; v.rtg1 = rtg1;
        v.e_en = e_en; v.e_pc0 = e_pc0; v.e_pc1 = e_pc1; v.e_tk = e_tk; v.e_tg0 = e_tg0;
        v.e_squash = e_squash; v.e_redir = e_redir; v.e_count = e_count;
        v.e_ready = e_ready; v.e_oerr = e_oerr;
        return v;
    endfunction

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic drive(
        input logic [1:0] pv, input logic [31:0] ppc0, input logic [31:0] ppc1,
        input logic [1:0] ptk, input logic [31:0] ptg0, input logic [31:0] ptg1,
        input logic [1:0] rv, input logic [31:0] rpc0, input logic [31:0] rpc1,
        input logic [1:0] rtk, input logic [31:0] rtg0, input logic [31:0] rtg1);
        push_valid       = pv;
        push_pc          = {ppc1, ppc0};
        push_pred_taken  = ptk;
        push_pred_target = {ptg1, ptg0};
        rt_valid         = rv;
        rt_pc            = {rpc1, rpc0};
        rt_taken         = rtk;
        rt_target        = {rtg1, rtg0};
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        @(negedge clock);
        reset = 1'b1;
    endtask

    vec_t vecs[8];
    logic [31:0] q[$];

    initial begin
        logic [31:0] a, b;

        reset = 1'b0;
        push_valid = '0; push_pc = '0; push_pred_taken = '0; push_pred_target = '0;
        rt_valid = '0; rt_pc = '0; rt_taken = '0; rt_target = '0;

        // ---- Reset state ----
        repeat (2) @(posedge clock);
        #1;
        check("rst_upd_en",   64'(upd_en), 0);
        check("rst_squash",   64'(squash), 0);
        check("rst_redirect", 64'(redirect_pc), 0);
        check("rst_order",    64'(order_err), 0);
        check("rst_count",    64'(count), 0);
        check("rst_ready",    64'(push_ready), 1);
        @(negedge clock);
        reset = 1'b1;

        // ---- Directed vectors ----
        //            pv     ppc0   ppc1   ptk    ptg0   ptg1   rv     rpc0   rpc1   rtk    rtg0   rtg1   e_en   e_pc0  e_pc1  e_tk   e_tg0  sq redir  cnt rdy oe
        vecs[0] = mk(2'b11, 'h100, 'h104, 2'b01, 'h200, 'h108, 2'b00, 0,     0,     2'b00, 0,     0,     2'b00, 0,     0,     2'b00, 0,     0, 0,     2,  1,  0);
        vecs[1] = mk(2'b00, 0,     0,     2'b00, 0,     0,     2'b11, 'h100, 'h104, 2'b01, 'h200, 'h108, 2'b11, 'h100, 'h104, 2'b01, 'h200, 0, 0,     0,  1,  0);
        vecs[2] = mk(2'b01, 'h40,  0,     2'b00, 'h44,  0,     2'b00, 0,     0,     2'b00, 0,     0,     2'b00, 0,     0,     2'b00, 0,     0, 0,     1,  1,  0);
        vecs[3] = mk(2'b01, 'h500, 0,     2'b00, 'h504, 0,     2'b01, 'h40,  0,     2'b01, 'h80,  0,     2'b01, 'h40,  0,     2'b01, 'h80,  1, 'h80,  0,  1,  0);
        vecs[4] = mk(2'b01, 'h600, 0,     2'b00, 'h604, 0,     2'b00, 0,     0,     2'b00, 0,     0,     2'b00, 0,     0,     2'b00, 0,     0, 0,     0,  1,  0);
        vecs[5] = mk(2'b11, 'h10,  'h14,  2'b01, 'h50,  'h18,  2'b00, 0,     0,     2'b00, 0,     0,     2'b00, 0,     0,     2'b00, 0,     0, 0,     2,  1,  0);
        vecs[6] = mk(2'b00, 0,     0,     2'b00, 0,     0,     2'b11, 'h10,  'h14,  2'b00, 0,     0,     2'b01, 'h10,  0,     2'b00, 0,     1, 'h14,  0,  1,  0);
        vecs[7] = mk(2'b11, 'h700, 'h704, 2'b00, 'h704, 'h708, 2'b00, 0,     0,     2'b00, 0,     0,     2'b00, 0,     0,     2'b00, 0,     0, 0,     0,  1,  0);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].pv, vecs[i].ppc0, vecs[i].ppc1, vecs[i].ptk, vecs[i].ptg0, vecs[i].ptg1,
                  vecs[i].rv, vecs[i].rpc0, vecs[i].rpc1, vecs[i].rtk, vecs[i].rtg0, vecs[i].rtg1);
            check($sformatf("v%0d_upd_en", i), 64'(upd_en), 64'(vecs[i].e_en));
            if (vecs[i].e_en[0]) begin
                check($sformatf("v%0d_upd_pc0", i), 64'(upd_pc[31:0]), 64'(vecs[i].e_pc0));
                check($sformatf("v%0d_upd_tg0", i), 64'(upd_target[31:0]), 64'(vecs[i].e_tg0));
            end
            if (vecs[i].e_en[1])
                check($sformatf("v%0d_upd_pc1", i), 64'(upd_pc[63:32]), 64'(vecs[i].e_pc1));
            check($sformatf("v%0d_upd_taken", i), 64'(upd_taken & upd_en), 64'(vecs[i].e_tk & vecs[i].e_en));
            check($sformatf("v%0d_squash", i), 64'(squash), 64'(vecs[i].e_squash));
            if (vecs[i].e_squash)
                check($sformatf("v%0d_redirect", i), 64'(redirect_pc), 64'(vecs[i].e_redir));
            check($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_count));
            check($sformatf("v%0d_ready", i), 64'(push_ready), 64'(vecs[i].e_ready));
            check($sformatf("v%0d_order", i), 64'(order_err), 64'(vecs[i].e_oerr));
        end

        // ---- Fill to DEPTH-1, backpressure, then drain ----
        for (int i = 0; i < DEPTH - 1; i++) begin
            check("fill_ready", 64'(push_ready), 1);
            a = 32'h1000 + 32'(4 * i);
            drive(2'b01, a, 0, 2'b00, a + 4, 0, 2'b00, 0, 0, 2'b00, 0, 0);
            q.push_back(a);
        end
        check("full_count", 64'(count), 64'(DEPTH - 1));
        check("full_ready", 64'(push_ready), 0);
        drive(2'b01, 'hDEAD, 0, 2'b00, 'hDEB1, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        check("full_push_ignored", 64'(count), 64'(DEPTH - 1));
        a = q.pop_front();
        drive(2'b00, 0, 0, 2'b00, 0, 0, 2'b01, a, 0, 2'b00, 0, 0);
        check("ret1_upd_en", 64'(upd_en), 1);
        check("ret1_upd_pc", 64'(upd_pc[31:0]), 64'(a));
        check("ret1_count", 64'(count), 64'(DEPTH - 2));
        check("ret1_ready", 64'(push_ready), 1);
        while (q.size() >= 2) begin
            a = q.pop_front();
            b = q.pop_front();
            drive(2'b00, 0, 0, 2'b00, 0, 0, 2'b11, a, b, 2'b00, 0, 0);
            check("drain_upd_en", 64'(upd_en), 3);
            check("drain_pc0", 64'(upd_pc[31:0]), 64'(a));
            check("drain_pc1", 64'(upd_pc[63:32]), 64'(b));
        end
        check("drain_count", 64'(count), 0);
        check("drain_order", 64'(order_err), 0);

        // ---- Concurrent push/retire streaming across 3x DEPTH entries ----
        drive(2'b11, 'h2000, 'h2004, 2'b00, 'h2004, 'h2008, 2'b00, 0, 0, 2'b00, 0, 0);
        q.push_back(32'h2000);
        q.push_back(32'h2004);
        for (int c = 0; c < 3 * DEPTH / 2; c++) begin
            logic [31:0] n0, n1;
            n0 = 32'h2008 + 32'(8 * c);
            n1 = n0 + 4;
            a = q.pop_front();
            b = q.pop_front();
            drive(2'b11, n0, n1, 2'b00, n0 + 4, n1 + 4, 2'b11, a, b, 2'b00, 0, 0);
            q.push_back(n0);
            q.push_back(n1);
            check("wrap_upd_en", 64'(upd_en), 3);
            check("wrap_pc0", 64'(upd_pc[31:0]), 64'(a));
            check("wrap_pc1", 64'(upd_pc[63:32]), 64'(b));
            check("wrap_count", 64'(count), 2);
            check("wrap_squash", 64'(squash), 0);
        end
        a = q.pop_front();
        b = q.pop_front();
        drive(2'b00, 0, 0, 2'b00, 0, 0, 2'b11, a, b, 2'b00, 0, 0);
        check("wrap_last_pc0", 64'(upd_pc[31:0]), 64'(a));
        check("wrap_last_pc1", 64'(upd_pc[63:32]), 64'(b));
        check("wrap_end_count", 64'(count), 0);
        check("wrap_order", 64'(order_err), 0);

        // ---- Reset mid-operation clears a pending squash ----
        drive(2'b01, 'h40, 0, 2'b00, 'h44, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        drive(2'b00, 0, 0, 2'b00, 0, 0, 2'b01, 'h40, 0, 2'b01, 'h80, 0);
        check("mid_squash_set", 64'(squash), 1);
        check("mid_redirect", 64'(redirect_pc), 'h80);
        reset = 1'b0;
        #1;
        check("mid_rst_squash", 64'(squash), 0);
        check("mid_rst_redirect", 64'(redirect_pc), 0);
        check("mid_rst_upd_en", 64'(upd_en), 0);
        @(negedge clock);
        reset = 1'b1;

        // ---- Order error on PC mismatch is sticky until reset ----
        drive(2'b01, 'h100, 0, 2'b00, 'h104, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        check("oe_pre", 64'(order_err), 0);
        drive(2'b00, 0, 0, 2'b00, 0, 0, 2'b01, 'h999, 0, 2'b00, 0, 0);
        check("oe_set", 64'(order_err), 1);
        check("oe_upd_en", 64'(upd_en), 1);
        check("oe_count", 64'(count), 0);
        check("oe_squash", 64'(squash), 0);
        repeat (3) idle();
        check("oe_sticky", 64'(order_err), 1);
        do_reset();
        #1;
        check("oe_cleared", 64'(order_err), 0);

        // ---- Retire on empty queue ----
        drive(2'b00, 0, 0, 2'b00, 0, 0, 2'b01, 'h300, 0, 2'b00, 0, 0);
        check("empty_ret_order", 64'(order_err), 1);
        check("empty_ret_count", 64'(count), 0);
        check("empty_ret_ready", 64'(push_ready), 1);
        do_reset();
        #1;
        check("final_order", 64'(order_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: guarantees the run ends even if the stimulus stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
